// File: rtl/spi_reg_ctrl_pkg.sv
// Shared command-byte layout, fill value and FSM state type for the SPI register sequencer.
package spi_reg_pkg;

    localparam int         CMD_WR_BIT   = 7;
    localparam int         CMD_INC_BIT  = 6;
    localparam int         CMD_ADDR_MSB = 5;
    localparam logic [7:0] TO_FILL      = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RD_REQ,
        RD_WAIT,
        RD_SHIFT,
        DONE
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic                  inc;
        logic [CMD_ADDR_MSB:0] addr;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c.wr   = b[CMD_WR_BIT];
        c.inc  = b[CMD_INC_BIT];
        c.addr = b[CMD_ADDR_MSB:0];
        return c;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Strobe-based register bus between the sequencer (master) and the config register file (slave).
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] o_reg_addr;
    logic [7:0]        o_reg_wdata;
    logic              o_reg_wr;
    logic              o_reg_rd;
    logic [7:0]        i_reg_rdata;
    logic              i_reg_rd_ack;

    modport master (
        output o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd,
        input  i_reg_rdata, i_reg_rd_ack
    );

    modport slave (
        input  o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd,
        output i_reg_rdata, i_reg_rd_ack
    );
endinterface

// File: rtl/spi_reg_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single level signal; resets to 1 (inactive CS).
module sync_2ff (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_reg_ctrl.sv
// Parses the SPI byte stream into single/burst register reads and writes and returns
// read data to spi_slave for MISO.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_b,
    input  logic                  i_spi_cs_b,
    input  logic                  i_rx_data_valid,
    input  logic [7:0]            i_rx_byte,
    output logic                  o_tx_data_valid,
    output logic [7:0]            o_tx_byte,
    spi_reg_ctrl_if.master        reg_bus,
    output logic                  o_busy,
    output logic                  o_rd_timeout
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    state_e            state, state_nxt;
    logic              cs_s, cs_d, cs_fall;
    logic [1:0]        settle_pipe;
    logic [ADDR_W-1:0] addr, addr_nxt, strobe_addr;
    logic              inc, inc_nxt;
    logic [CNT_W-1:0]  to_cnt, to_cnt_nxt;
    logic              wr_nxt, rd_nxt, tx_vld_nxt, timeout_hit;
    logic [7:0]        tx_byte_nxt;
    cmd_t              cmd;

    sync_2ff u_cs_sync (
        .clk   (i_sys_clk),
        .rst_b (i_rst_b),
        .d     (i_spi_cs_b),
        .q     (cs_s)
    );

    // The synchroniser comes out of reset at 1 regardless of the pin, so edge detection
    // waits until it has settled; a CS already low at reset release is not a new frame.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            settle_pipe <= '0;
            cs_d        <= 1'b0;
        end else begin
            settle_pipe <= {settle_pipe[0], 1'b1};
            cs_d        <= settle_pipe[1] ? cs_s : 1'b0;
        end
    end

    assign cs_fall = cs_d & ~cs_s;
    assign cmd     = decode_cmd(i_rx_byte);
    assign o_busy  = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        inc_nxt     = inc;
        strobe_addr = addr;
        to_cnt_nxt  = to_cnt;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        tx_vld_nxt  = 1'b0;
        tx_byte_nxt = o_tx_byte;
        timeout_hit = 1'b0;

        case (state)
            IDLE: if (cs_fall) state_nxt = CMD;
            CMD: if (i_rx_data_valid) begin
                inc_nxt  = cmd.inc;
                addr_nxt = cmd.addr[ADDR_W-1:0];
                if (cmd.wr) begin
                    state_nxt = WDATA;
                end else begin
                    state_nxt   = RD_REQ;
                    rd_nxt      = 1'b1;
                    strobe_addr = addr_nxt;
                end
            end
            WDATA: if (i_rx_data_valid) begin
                wr_nxt = 1'b1;
                if (inc) addr_nxt  = addr + ADDR_W'(1);
                else     state_nxt = DONE;
            end
            RD_REQ: begin
                to_cnt_nxt = '0;
                state_nxt  = RD_WAIT;
            end
            RD_WAIT: begin
                if (reg_bus.i_reg_rd_ack) begin
                    tx_vld_nxt  = 1'b1;
                    tx_byte_nxt = reg_bus.i_reg_rdata;
                    state_nxt   = RD_SHIFT;
                end else if (to_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                    tx_vld_nxt  = 1'b1;
                    tx_byte_nxt = TO_FILL;
                    timeout_hit = 1'b1;
                    state_nxt   = RD_SHIFT;
                end else begin
                    to_cnt_nxt = to_cnt + CNT_W'(1);
                end
            end
            RD_SHIFT: if (i_rx_data_valid) begin
                if (inc) begin
                    addr_nxt    = addr + ADDR_W'(1);
                    strobe_addr = addr_nxt;
                    rd_nxt      = 1'b1;
                    state_nxt   = RD_REQ;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: ;
            default: state_nxt = IDLE;
        endcase

        // CS deassertion abandons the frame; only a write byte already in hand commits.
        if (cs_s && state != IDLE) begin
            state_nxt   = IDLE;
            rd_nxt      = 1'b0;
            tx_vld_nxt  = 1'b0;
            tx_byte_nxt = o_tx_byte;
            timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state               <= IDLE;
            addr                <= '0;
            inc                 <= 1'b0;
            to_cnt              <= '0;
            reg_bus.o_reg_addr  <= '0;
            reg_bus.o_reg_wdata <= 8'h00;
            reg_bus.o_reg_wr    <= 1'b0;
            reg_bus.o_reg_rd    <= 1'b0;
            o_tx_data_valid     <= 1'b0;
            o_tx_byte           <= 8'h00;
            o_rd_timeout        <= 1'b0;
        end else begin
            state            <= state_nxt;
            addr             <= addr_nxt;
            inc              <= inc_nxt;
            to_cnt           <= to_cnt_nxt;
            reg_bus.o_reg_wr <= wr_nxt;
            reg_bus.o_reg_rd <= rd_nxt;
            if (wr_nxt || rd_nxt) reg_bus.o_reg_addr  <= strobe_addr;
            if (wr_nxt)           reg_bus.o_reg_wdata <= i_rx_byte;
            o_tx_data_valid  <= tx_vld_nxt;
            o_tx_byte        <= tx_byte_nxt;
            if (cs_fall)          o_rd_timeout <= 1'b0;
            else if (timeout_hit) o_rd_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed + random frames against a transaction-level model of the register sequencer.
module tb_spi_reg_ctrl;
    import spi_reg_pkg::*;

    localparam int ADDR_W     = 6;
    localparam int RD_TIMEOUT = 16;
    localparam int RD_GAP     = RD_TIMEOUT + 8;

    logic       i_sys_clk = 1'b0;
    logic       i_rst_b;
    logic       i_spi_cs_b;
    logic       i_rx_data_valid;
    logic [7:0] i_rx_byte;
    logic       o_tx_data_valid;
    logic [7:0] o_tx_byte;
    logic       o_busy;
    logic       o_rd_timeout;

    spi_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    spi_reg_ctrl #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .i_sys_clk       (i_sys_clk),
        .i_rst_b         (i_rst_b),
        .i_spi_cs_b      (i_spi_cs_b),
        .i_rx_data_valid (i_rx_data_valid),
        .i_rx_byte       (i_rx_byte),
        .o_tx_data_valid (o_tx_data_valid),
        .o_tx_byte       (o_tx_byte),
        .reg_bus         (bus),
        .o_busy          (o_busy),
        .o_rd_timeout    (o_rd_timeout)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    ev_t        wr_q[$], rd_q[$], tx_q[$];
    int         rx_q[$];
    int         delay_q[$];
    logic [7:0] stim_q[$];
    logic [7:0] mem[64];
    logic [7:0] ref_mem[64];
    int         cyc = 0;
    int         cd;
    logic [5:0] rd_addr;
    int         n_chk = 0;
    int         n_pass = 0;

    // Observer and register-file responder; acks arrive a queued number of cycles after o_reg_rd.
    always @(negedge i_sys_clk) begin
        ev_t e;
        cyc++;
        if (cyc == 1) for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 5);
        if (i_rx_data_valid === 1'b1) rx_q.push_back(cyc);
        if (bus.o_reg_wr === 1'b1) begin
            e.cyc = cyc; e.addr = int'(bus.o_reg_addr); e.data = int'(bus.o_reg_wdata);
            wr_q.push_back(e);
            mem[bus.o_reg_addr] = bus.o_reg_wdata;
        end
        if (o_tx_data_valid === 1'b1) begin
            e.cyc = cyc; e.addr = 0; e.data = int'(o_tx_byte);
            tx_q.push_back(e);
        end
        bus.i_reg_rd_ack = 1'b0;
        if (i_rst_b !== 1'b1) begin
            cd = 0;
            bus.i_reg_rdata = 8'h00;
        end else if (bus.o_reg_rd === 1'b1) begin
            e.cyc = cyc; e.addr = int'(bus.o_reg_addr); e.data = 0;
            rd_q.push_back(e);
            rd_addr = bus.o_reg_addr;
            cd = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.i_reg_rd_ack = 1'b1;
                bus.i_reg_rdata  = mem[rd_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        i_rx_data_valid = 1'b1;
        i_rx_byte       = b;
        tick(1);
        i_rx_data_valid = 1'b0;
        tick(gap);
    endtask

    task automatic clear_logs();
        wr_q.delete(); rd_q.delete(); tx_q.delete(); rx_q.delete();
    endtask

    // One CS frame: command byte then stim_q bytes; delay_q holds ack delays (0 = never).
    task automatic run_txn(input logic [7:0] cmd, input string tag);
        ev_t  ewr[$], erd[$], etx[$], e;
        int   dly[$];
        int   a, nrd, d;
        bit   is_wr, inc, exp_to;
        is_wr  = cmd[7];
        inc    = cmd[6];
        a      = int'(cmd[5:0]);
        dly    = delay_q;
        exp_to = 1'b0;
        if (is_wr) begin
            for (int i = 0; i < stim_q.size(); i++) begin
                if (i > 0 && !inc) break;
                e.cyc = 0; e.addr = a; e.data = int'(stim_q[i]);
                ewr.push_back(e);
                ref_mem[a] = stim_q[i];
                a = (a + 1) % 64;
            end
        end else begin
            nrd = inc ? stim_q.size() + 1 : 1;
            for (int k = 0; k < nrd; k++) begin
                d = (k < dly.size()) ? dly[k] : 0;
                e.cyc = 0; e.addr = a; e.data = 0;
                erd.push_back(e);
                e.cyc  = (d >= 1 && d <= RD_TIMEOUT) ? d + 1 : RD_TIMEOUT + 1;
                e.data = (d >= 1 && d <= RD_TIMEOUT) ? int'(ref_mem[a]) : int'(TO_FILL);
                if (!(d >= 1 && d <= RD_TIMEOUT)) exp_to = 1'b1;
                etx.push_back(e);
                a = (a + 1) % 64;
            end
        end

        clear_logs();
        i_spi_cs_b = 1'b0;
        tick(4);
        chk({tag, " busy@cs"}, 32'(o_busy), 32'd1);
        chk({tag, " to_clr"}, 32'(o_rd_timeout), 32'd0);
        send(cmd, is_wr ? 3 : RD_GAP);
        foreach (stim_q[i]) send(stim_q[i], is_wr ? 3 : RD_GAP);

        chk({tag, " n_wr"}, 32'(wr_q.size()), 32'(ewr.size()));
        chk({tag, " n_rd"}, 32'(rd_q.size()), 32'(erd.size()));
        chk({tag, " n_tx"}, 32'(tx_q.size()), 32'(etx.size()));
        for (int i = 0; i < ewr.size() && i < wr_q.size(); i++) begin
            chk($sformatf("%s wr%0d addr", tag, i), 32'(wr_q[i].addr), 32'(ewr[i].addr));
            chk($sformatf("%s wr%0d data", tag, i), 32'(wr_q[i].data), 32'(ewr[i].data));
            if (i + 1 < rx_q.size())
                chk($sformatf("%s wr%0d lat", tag, i), 32'(wr_q[i].cyc - rx_q[i+1]), 32'd1);
        end
        for (int k = 0; k < erd.size() && k < rd_q.size(); k++) begin
            chk($sformatf("%s rd%0d addr", tag, k), 32'(rd_q[k].addr), 32'(erd[k].addr));
            if (k < rx_q.size())
                chk($sformatf("%s rd%0d lat", tag, k), 32'(rd_q[k].cyc - rx_q[k]), 32'd1);
            if (k < tx_q.size()) begin
                chk($sformatf("%s tx%0d data", tag, k), 32'(tx_q[k].data), 32'(etx[k].data));
                chk($sformatf("%s tx%0d lat", tag, k), 32'(tx_q[k].cyc - rd_q[k].cyc), 32'(etx[k].cyc));
            end
        end
        chk({tag, " timeout"}, 32'(o_rd_timeout), 32'(exp_to));
        chk({tag, " busy@end"}, 32'(o_busy), 32'd1);

        i_spi_cs_b = 1'b1;
        tick(6);
        chk({tag, " busy@idle"}, 32'(o_busy), 32'd0);
        chk({tag, " to_sticky"}, 32'(o_rd_timeout), 32'(exp_to));
        stim_q.delete();
        delay_q.delete();
    endtask

    initial begin
        logic [7:0] c;
        int         n, r;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);
        i_rst_b = 1'b0; i_spi_cs_b = 1'b1; i_rx_data_valid = 1'b0; i_rx_byte = 8'h00;
        tick(3);
        i_rst_b = 1'b1;
        tick(4);
        chk("rst tx_byte", 32'(o_tx_byte), 32'h0);
        chk("rst tx_vld", 32'(o_tx_data_valid), 32'h0);
        chk("rst addr", 32'(bus.o_reg_addr), 32'h0);
        chk("rst wdata", 32'(bus.o_reg_wdata), 32'h0);
        chk("rst wr", 32'(bus.o_reg_wr), 32'h0);
        chk("rst rd", 32'(bus.o_reg_rd), 32'h0);
        chk("rst busy", 32'(o_busy), 32'h0);
        chk("rst timeout", 32'(o_rd_timeout), 32'h0);

        stim_q = '{8'h3C, 8'h99};              run_txn(8'h85, "wr_single");
        stim_q = '{8'h11, 8'h22};              run_txn(8'hFF, "wr_wrap");
        stim_q = '{8'hA5, 8'h5A};              run_txn(8'hC2, "wr_prep");
        stim_q = '{8'h00}; delay_q = '{3, 3};  run_txn(8'h42, "rd_burst");
        delay_q = '{0};                        run_txn(8'h07, "rd_timeout");
        delay_q = '{16};                       run_txn(8'h0A, "rd_edge16");
        stim_q = '{8'h00}; delay_q = '{1, 17}; run_txn(8'h4B, "rd_late");

        // Abort: CS rises while the read waits; the late ack must be ignored.
        clear_logs();
        delay_q = '{6};
        i_spi_cs_b = 1'b0;
        tick(4);
        send(8'h07, 2);
        i_spi_cs_b = 1'b1;
        tick(30);
        chk("abort n_rd", 32'(rd_q.size()), 32'd1);
        chk("abort n_tx", 32'(tx_q.size()), 32'd0);
        chk("abort busy", 32'(o_busy), 32'd0);
        delay_q.delete();

        // Reset mid-burst write with CS held low.
        clear_logs();
        i_spi_cs_b = 1'b0;
        tick(4);
        send(8'hC0, 3);
        send(8'h01, 3);
        ref_mem[0] = 8'h01;
        i_rst_b = 1'b0;
        #2;
        chk("rst_mid wr", 32'(bus.o_reg_wr), 32'h0);
        chk("rst_mid addr", 32'(bus.o_reg_addr), 32'h0);
        chk("rst_mid tx_byte", 32'(o_tx_byte), 32'h0);
        chk("rst_mid busy", 32'(o_busy), 32'h0);
        tick(2);
        i_rst_b = 1'b1;
        tick(5);
        send(8'h02, 3);
        send(8'h03, 3);
        chk("rst_mid n_wr", 32'(wr_q.size()), 32'd1);
        chk("rst_mid idle", 32'(o_busy), 32'd0);
        i_spi_cs_b = 1'b1;
        tick(6);
        stim_q = '{8'h77}; run_txn(8'h81, "post_rst");
        stim_q = '{8'h00}; delay_q = '{2, 2}; run_txn(8'h40, "rd_after_rst");

        for (int t = 0; t < 20; t++) begin
            c = 8'($urandom);
            n = c[7] ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            for (int i = 0; i <= n; i++) begin
                r = int'($urandom_range(0, 9));
                delay_q.push_back(r == 0 ? 0 : (r == 1 ? int'($urandom_range(17, 20))
                                                       : int'($urandom_range(1, RD_TIMEOUT))));
            end
            run_txn(c, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
